// File: rtl/encoder_8to3_seq_if.sv
// rtl/encoder_8to3_seq_if.sv - request/code handshake bundle for encoder_8to3_seq
//
// Purpose: groups the request inputs and the registered code/handshake
// outputs of encoder_8to3_seq so producer and consumer share one port.
//
// Signals:
//   ENABLE     producer -> encoder  1 = sample usr_input into pending set
//   usr_input  producer -> encoder  8 request lines, bit i requests code i
//   ACK        producer -> encoder  consumer accepts Dout while VALID is high
//   Dout       encoder -> producer  3-bit code of the selected request
//   VALID      encoder -> producer  Dout holds a code awaiting ACK
//   PEND       encoder -> producer  pending-request set
//   OVF        encoder -> producer  sticky overflow flag
//
// Modports: master = stimulus/consumer side, slave = encoder side.

interface encoder_8to3_seq_if;
  logic       ENABLE;
  logic [7:0] usr_input;
  logic       ACK;
  logic [2:0] Dout;
  logic       VALID;
  logic [7:0] PEND;
  logic       OVF;

  modport master (
    output ENABLE, usr_input, ACK,
    input  Dout, VALID, PEND, OVF
  );

  modport slave (
    input  ENABLE, usr_input, ACK,
    output Dout, VALID, PEND, OVF
  );
endinterface

// File: rtl/encoder_8to3_seq.sv
// rtl/encoder_8to3_seq.sv - sequential 8-to-3 priority encoder with ACK handshake
//
// Purpose: collects multi-hot requests into a sticky pending set and presents
// the highest-priority pending code (bit 7 highest) on Dout with VALID. The
// code is held until ACK, then its pending bit is cleared on the same edge.
//
// Ports:
//   clk    single clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    encoder_8to3_seq_if.slave (ENABLE, usr_input, ACK in;
//          Dout, VALID, PEND, OVF out, all outputs registered)
//
// Build option: define ENC_OVF_DETECT_EN to enable sticky overflow detection
// (request arriving on an already-pending bit). Without it OVF is tied to 0.

module encoder_8to3_seq (
  input  logic                      clk,
  input  logic                      rst_n,
  encoder_8to3_seq_if.slave         bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] dout_q, dout_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] clear_mask;

  // Index of the highest set bit; the upward scan lets higher bits overwrite.
  function automatic logic [2:0] prio_index(input logic [7:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d    = state_q;
    dout_d     = dout_q;
    clear_mask = 8'h00;

    case (state_q)
      IDLE: begin
        // Decision uses the registered pending set, which gives the
        // two-edge request-to-VALID latency and the one-cycle bubble.
        if (|pend_q) begin
          state_d = HOLD;
          dout_d  = prio_index(pend_q);
        end
      end
      HOLD: begin
        if (bus.ACK) begin
          state_d    = IDLE;
          clear_mask = 8'h01 << dout_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // The OR comes after the clear so a fresh request on the bit being
    // acknowledged survives.
    pend_d = pend_q & ~clear_mask;
    if (bus.ENABLE) begin
      pend_d = pend_d | bus.usr_input;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dout_q  <= 3'd0;
      pend_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      pend_q  <= pend_d;
    end
  end

`ifdef ENC_OVF_DETECT_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.ENABLE && |(bus.usr_input & pend_q & ~clear_mask)) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.OVF = ovf_q;
`else
  assign bus.OVF = 1'b0;
`endif

  assign bus.Dout  = dout_q;
  assign bus.VALID = (state_q == HOLD);
  assign bus.PEND  = pend_q;

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// tb/tb_encoder_8to3_seq.sv - directed self-checking bench for encoder_8to3_seq

module tb_encoder_8to3_seq;

  logic clk;
  logic rst_n;
  int   total_checks;
  int   passed_checks;
  int   failed_checks;

  encoder_8to3_seq_if bus ();

  encoder_8to3_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ENC_OVF_DETECT_EN
  localparam logic OVF_AFTER_REPEAT = 1'b1;
`else
  localparam logic OVF_AFTER_REPEAT = 1'b0;
`endif

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else begin
      failed_checks++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic valid, input logic [2:0] dout,
                           input logic [7:0] pend);
    check({tag, ".valid"}, {7'd0, bus.VALID}, {7'd0, valid});
    check({tag, ".dout"},  {5'd0, bus.Dout},  {5'd0, dout});
    check({tag, ".pend"},  bus.PEND,          pend);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    failed_checks = 0;

    rst_n         = 1'b0;
    bus.ENABLE    = 1'b1;
    bus.usr_input = 8'h00;
    bus.ACK       = 1'b0;
    #12;
    check_out("reset", 1'b0, 3'd0, 8'h00);
    check("reset.ovf", {7'd0, bus.OVF}, 8'h00);
    step();
    rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      step();
      check_out($sformatf("idle%0d", i), 1'b0, 3'd0, 8'h00);
    end

    // Two requests drained with ACK held high: 5, bubble, 2
    bus.usr_input = 8'b0010_0100;
    bus.ACK       = 1'b1;
    step();
    check_out("drain.e1", 1'b0, 3'd0, 8'h24);
    bus.usr_input = 8'h00;
    step();
    check_out("drain.e2", 1'b1, 3'd5, 8'h24);
    step();
    check_out("drain.e3", 1'b0, 3'd5, 8'h04);
    step();
    check_out("drain.e4", 1'b1, 3'd2, 8'h04);
    step();
    check_out("drain.e5", 1'b0, 3'd2, 8'h00);
    step();
    check_out("drain.e6", 1'b0, 3'd2, 8'h00);

    // Higher-priority arrival must not preempt a held code
    bus.ACK       = 1'b0;
    bus.usr_input = 8'h01;
    step();
    check_out("hold.a", 1'b0, 3'd2, 8'h01);
    bus.usr_input = 8'h00;
    step();
    check_out("hold.b", 1'b1, 3'd0, 8'h01);
    bus.usr_input = 8'h80;
    step();
    check_out("hold.c", 1'b1, 3'd0, 8'h81);
    bus.usr_input = 8'h00;
    step();
    check_out("hold.d", 1'b1, 3'd0, 8'h81);
    bus.ACK = 1'b1;
    step();
    check_out("hold.e", 1'b0, 3'd0, 8'h80);
    bus.ACK = 1'b0;
    step();
    check_out("hold.f", 1'b1, 3'd7, 8'h80);
    bus.ACK = 1'b1;
    step();
    check_out("hold.g", 1'b0, 3'd7, 8'h00);
    bus.ACK = 1'b0;

    // ENABLE low ignores requests; ACK with VALID low is ignored
    bus.ENABLE    = 1'b0;
    bus.usr_input = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      bus.ACK = i[0];
      step();
      check_out($sformatf("dis%0d", i), 1'b0, 3'd7, 8'h00);
    end
    bus.ACK       = 1'b0;
    bus.ENABLE    = 1'b1;
    bus.usr_input = 8'h00;

    // Clear and new request on the same bit: new request wins
    bus.usr_input = 8'h08;
    step();
    check_out("same.a", 1'b0, 3'd7, 8'h08);
    bus.usr_input = 8'h00;
    step();
    check_out("same.b", 1'b1, 3'd3, 8'h08);
    bus.ACK       = 1'b1;
    bus.usr_input = 8'h08;
    step();
    check_out("same.c", 1'b0, 3'd3, 8'h08);
    check("same.c.ovf", {7'd0, bus.OVF}, 8'h00);
    bus.ACK       = 1'b0;
    bus.usr_input = 8'h00;
    step();
    check_out("same.d", 1'b1, 3'd3, 8'h08);
    bus.usr_input = 8'h08;
    step();
    check_out("same.e", 1'b1, 3'd3, 8'h08);
    check("same.e.ovf", {7'd0, bus.OVF}, {7'd0, OVF_AFTER_REPEAT});
    bus.usr_input = 8'h00;
    bus.ACK       = 1'b1;
    step();
    check_out("same.f", 1'b0, 3'd3, 8'h00);
    check("same.f.ovf", {7'd0, bus.OVF}, {7'd0, OVF_AFTER_REPEAT});
    bus.ACK = 1'b0;

    // Asynchronous reset mid-HOLD
    bus.usr_input = 8'hC0;
    step();
    check_out("arst.a", 1'b0, 3'd3, 8'hC0);
    bus.usr_input = 8'h00;
    step();
    check_out("arst.b", 1'b1, 3'd7, 8'hC0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("arst.c", 1'b0, 3'd0, 8'h00);
    check("arst.c.ovf", {7'd0, bus.OVF}, 8'h00);
    bus.usr_input = 8'h02;
    step();
    check_out("arst.d", 1'b0, 3'd0, 8'h00);
    rst_n = 1'b1;
    step();
    check_out("arst.e", 1'b0, 3'd0, 8'h02);
    bus.usr_input = 8'h00;
    step();
    check_out("arst.f", 1'b1, 3'd1, 8'h02);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
